ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 26 ++
 rtl/ram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side bus bundle for ram_arbiter: level request, registered
// grant, single-cycle rd/wr pulses and the routed completion path.
interface ram_arbiter_if #(
    parameter int ADDRESS_WIDTH = 16
);
    logic                     req;
    logic                     gnt;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     rd;
    logic                     wr;
    logic [31:0]              data_wr;
    logic [31:0]              data_rd;
    logic                     data_valid;

    // Requester view: drives the request and access pulses, sees grant and completion.
    modport master (
        output req, address, rd, wr, data_wr,
        input  gnt, data_rd, data_valid
    );

    // Arbiter view: samples the requester, returns grant and completion.
    modport slave (
        input  req, address, rd, wr, data_wr,
        output gnt, data_rd, data_valid
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM. A requester keeps the
// grant for as long as it holds req (no preemption). Ties from IDLE are broken
// by an alternating priority pointer. At most one RAM access is in flight; a
// new one may be issued on the cycle the previous one completes. Completions
// are routed by the owner captured at issue time, so a response that lands
// after the grant has moved on still reaches the right requester. Protocol
// violations raise a sticky proto_err.
module ram_arbiter #(
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    ram_arbiter_if.slave             m0,
    ram_arbiter_if.slave             m1,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_rd,
    output logic                     ram_wr,
    output logic [31:0]              ram_data_wr,
    input  logic [31:0]              ram_data_rd,
    input  logic                     ram_data_valid,
    output logic                     proto_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   prio_q;
    logic   prio_d;
    logic   outstanding_q;
    logic   outstanding_d;
    logic   owner_q;
    logic   owner_d;
    logic   proto_err_q;
    logic   proto_err_d;
    // High only during the first cycle after reset is released: a stale
    // completion from an aborted access is tolerated then, and no grant is
    // given so the first grant lands on the second edge.
    logic   fresh_q;
    logic   fresh_d;

    logic   busy;
    logic   issue;
    logic   m0_access;
    logic   m1_access;
    logic   violation;

    // Grants are pure decodes of the state register.
    assign m0.gnt    = (state_q == GRANT0);
    assign m1.gnt    = (state_q == GRANT1);
    assign proto_err = proto_err_q;

    // Forward the granted requester onto the RAM bus, throttled while an access is in flight.
    always_comb begin
        busy        = outstanding_q & ~ram_data_valid;
        m0_access   = m0.rd | m0.wr;
        m1_access   = m1.rd | m1.wr;
        ram_address = '0;
        ram_data_wr = '0;
        ram_rd      = 1'b0;
        ram_wr      = 1'b0;
        case (state_q)
            GRANT0: begin
                ram_address = m0.address;
                ram_data_wr = m0.data_wr;
                ram_rd      = m0.rd & ~busy;
                ram_wr      = m0.wr & ~busy & ~m0.rd;
            end
            GRANT1: begin
                ram_address = m1.address;
                ram_data_wr = m1.data_wr;
                ram_rd      = m1.rd & ~busy;
                ram_wr      = m1.wr & ~busy & ~m1.rd;
            end
            default: begin
            end
        endcase
        issue = ram_rd | ram_wr;
    end

    // Route RAM completions to whoever issued the access in flight.
    always_comb begin
        m0.data_rd    = (owner_q == 1'b0) ? ram_data_rd : '0;
        m1.data_rd    = (owner_q == 1'b1) ? ram_data_rd : '0;
        m0.data_valid = ram_data_valid & outstanding_q & (owner_q == 1'b0);
        m1.data_valid = ram_data_valid & outstanding_q & (owner_q == 1'b1);
    end

    // Detect protocol violations and accumulate them into the sticky flag.
    always_comb begin
        violation = 1'b0;
        if (m0_access && (state_q != GRANT0)) begin
            violation = 1'b1;
        end
        if (m1_access && (state_q != GRANT1)) begin
            violation = 1'b1;
        end
        if ((state_q == GRANT0) && m0_access && busy) begin
            violation = 1'b1;
        end
        if ((state_q == GRANT1) && m1_access && busy) begin
            violation = 1'b1;
        end
        if (ram_data_valid && !outstanding_q && !fresh_q) begin
            violation = 1'b1;
        end
        proto_err_d = proto_err_q | violation;
    end

    // Track the single in-flight access and remember who issued it.
    always_comb begin
        outstanding_d = outstanding_q;
        owner_d       = owner_q;
        if (issue) begin
            outstanding_d = 1'b1;
            owner_d       = (state_q == GRANT1);
        end else if (ram_data_valid) begin
            outstanding_d = 1'b0;
        end
    end

    // Grant selection and release; a grant is only dropped once req is low and nothing is pending.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        fresh_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fresh_q) begin
                    if (m0.req && m1.req) begin
                        state_d = prio_q ? GRANT1 : GRANT0;
                        prio_d  = ~prio_q;
                    end else if (m0.req) begin
                        state_d = GRANT0;
                    end else if (m1.req) begin
                        state_d = GRANT1;
                    end
                end
            end
            GRANT0: begin
                if (!m0.req && !outstanding_q && !issue) begin
                    state_d = IDLE;
                end
            end
            GRANT1: begin
                if (!m1.req && !outstanding_q && !issue) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously so an aborted access is dropped at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            outstanding_q <= 1'b0;
            owner_q       <= 1'b0;
            proto_err_q   <= 1'b0;
            fresh_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            outstanding_q <= outstanding_d;
            owner_q       <= owner_d;
            proto_err_q   <= proto_err_d;
            fresh_q       <= fresh_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a behavioural RAM, a cycle-level
// reference model checked every cycle, directed scenarios with literal
// expectations, and randomized requester traffic.
module tb_ram_arbiter;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic          req_s   [2];
    logic          rd_s    [2];
    logic          wr_s    [2];
    logic [AW-1:0] addr_s  [2];
    logic [31:0]   wdat_s  [2];
    logic          ram_valid_s;
    logic [31:0]   ram_rdata_s;

    logic [AW-1:0] ram_address;
    logic          ram_rd;
    logic          ram_wr;
    logic [31:0]   ram_data_wr;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    ram_arbiter_if #(.ADDRESS_WIDTH(AW)) m0 ();
    ram_arbiter_if #(.ADDRESS_WIDTH(AW)) m1 ();

    assign m0.req     = req_s[0];
    assign m0.rd      = rd_s[0];
    assign m0.wr      = wr_s[0];
    assign m0.address = addr_s[0];
    assign m0.data_wr = wdat_s[0];
    assign m1.req     = req_s[1];
    assign m1.rd      = rd_s[1];
    assign m1.wr      = wr_s[1];
    assign m1.address = addr_s[1];
    assign m1.data_wr = wdat_s[1];

    ram_arbiter #(.ADDRESS_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0             (m0),
        .m1             (m1),
        .ram_address    (ram_address),
        .ram_rd         (ram_rd),
        .ram_wr         (ram_wr),
        .ram_data_wr    (ram_data_wr),
        .ram_data_rd    (ram_rdata_s),
        .ram_data_valid (ram_valid_s),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    // Single comparison point: every check goes through here.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic gnt_of(input int n);
        return (n == 0) ? m0.gnt : m1.gnt;
    endfunction

    function automatic logic vld_of(input int n);
        return (n == 0) ? m0.data_valid : m1.data_valid;
    endfunction

    function automatic logic [31:0] data_of(input int n);
        return (n == 0) ? m0.data_rd : m1.data_rd;
    endfunction

    // ---------------- behavioural RAM ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    logic [31:0] mem [logic [AW-1:0]];
    resp_t       rq [$];
    int          cyc = 0;
    int          ram_lat = 1;
    resp_t       new_resp;

    // Unwritten words read back as the word index replicated in every byte.
    function automatic logic [31:0] mem_read(input logic [AW-1:0] a);
        logic [7:0] b;
        b = a[9:2];
        if (mem.exists(a)) return mem[a];
        return {4{b}};
    endfunction

    // RAM accepts an access at the clock edge ending the cycle it is driven.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            rq.delete();
        end else if (ram_rd || ram_wr) begin
            if (ram_wr) begin
                mem[ram_address] = ram_data_wr;
                new_resp.data = $urandom;
            end else begin
                new_resp.data = mem_read(ram_address);
            end
            new_resp.due = cyc + int'($urandom_range(ram_lat, 1));
            if (rq.size() > 0 && new_resp.due <= rq[rq.size()-1].due)
                new_resp.due = rq[rq.size()-1].due + 1;
            rq.push_back(new_resp);
        end
    end

    // RAM response driver; read-data bus carries noise when not valid.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (rst && rq.size() > 0 && rq[0].due <= cyc) begin
            ram_valid_s = 1'b1;
            ram_rdata_s = rq[0].data;
            void'(rq.pop_front());
        end else begin
            ram_valid_s = 1'b0;
            ram_rdata_s = $urandom;
        end
    end

    // ---------------- reference model ----------------
    int   md_holder;
    logic md_prio, md_pend, md_owner, md_err, md_fresh;
    logic seen_vld [2];
    int   h;
    logic e_rd, e_wr, e_busy, e_issue, viol;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wd;

    // Compare every cycle, then advance the model by the arbitration rules.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            md_holder = -1; md_prio = 1'b0; md_pend = 1'b0;
            md_owner = 1'b0; md_err = 1'b0; md_fresh = 1'b1;
        end
        h      = md_holder;
        e_busy = md_pend && !ram_valid_s;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
        if (h >= 0) begin
            e_rd   = rd_s[h] && !e_busy;
            e_wr   = wr_s[h] && !e_busy && !rd_s[h];
            e_addr = addr_s[h];
            e_wd   = wdat_s[h];
        end
        e_issue = e_rd || e_wr;

        check_output("gnt0", 32'(m0.gnt), 32'(h == 0));
        check_output("gnt1", 32'(m1.gnt), 32'(h == 1));
        check_output("ram_rd", 32'(ram_rd), 32'(e_rd));
        check_output("ram_wr", 32'(ram_wr), 32'(e_wr));
        check_output("ram_address", 32'(ram_address), 32'(e_addr));
        check_output("ram_data_wr", ram_data_wr, e_wd);
        check_output("valid0", 32'(m0.data_valid), 32'(ram_valid_s && md_pend && md_owner == 1'b0));
        check_output("valid1", 32'(m1.data_valid), 32'(ram_valid_s && md_pend && md_owner == 1'b1));
        check_output("data0", m0.data_rd, (md_owner == 1'b0) ? ram_rdata_s : 32'h0);
        check_output("data1", m1.data_rd, (md_owner == 1'b1) ? ram_rdata_s : 32'h0);
        check_output("proto_err", 32'(proto_err), 32'(md_err));
        seen_vld[0] = m0.data_valid;
        seen_vld[1] = m1.data_valid;

        if (rst) begin
            viol = 1'b0;
            for (int n = 0; n < 2; n++)
                if ((rd_s[n] || wr_s[n]) && h != n) viol = 1'b1;
            if (h >= 0 && (rd_s[h] || wr_s[h]) && e_busy) viol = 1'b1;
            if (ram_valid_s && !md_pend && !md_fresh) viol = 1'b1;
            md_err = md_err | viol;
            if (h < 0) begin
                if (!md_fresh) begin
                    if (req_s[0] && req_s[1]) begin
                        md_holder = int'(md_prio);
                        md_prio   = !md_prio;
                    end else if (req_s[0]) md_holder = 0;
                    else if (req_s[1]) md_holder = 1;
                end
            end else if (!req_s[h] && !md_pend && !e_issue) begin
                md_holder = -1;
            end
            if (e_issue) begin
                md_pend  = 1'b1;
                md_owner = (h == 1);
            end else if (ram_valid_s) begin
                md_pend = 1'b0;
            end
            md_fresh = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            req_s[n] = 1'b0; rd_s[n] = 1'b0; wr_s[n] = 1'b0;
            addr_s[n] = '0; wdat_s[n] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Waits (bounded) for a grant; returns the granted index or -1.
    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0.gnt) begin who = 0; break; end
            if (m1.gnt) begin who = 1; break; end
        end
        check_output("wait_grant_done", 32'(who >= 0), 32'h1);
    endtask

    // Drops req and waits (bounded) for the grant to go away.
    task automatic release_req(input int n);
        logic gone;
        gone = 1'b0;
        step();
        req_s[n] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!gnt_of(n)) begin gone = 1'b1; break; end
        end
        check_output("release_done", 32'(gone), 32'h1);
    endtask

    // One access from a granted requester; waits (bounded) for its completion.
    task automatic apply_stimulus(input int n, input bit is_wr, input logic [AW-1:0] a,
                                  input logic [31:0] d, output logic [31:0] rdata);
        logic got;
        got = 1'b0;
        rdata = '0;
        step();
        rd_s[n] = !is_wr; wr_s[n] = is_wr; addr_s[n] = a; wdat_s[n] = d;
        step();
        rd_s[n] = 1'b0; wr_s[n] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vld_of(n)) begin rdata = data_of(n); got = 1'b1; break; end
        end
        check_output("access_done", 32'(got), 32'h1);
    endtask

    // Random requester traffic; rogue adds occasional out-of-protocol pulses.
    task automatic random_phase(input int cycles, input bit rogue);
        int   ops [2];
        int   wcnt [2];
        logic waiting [2];
        logic idle;
        for (int n = 0; n < 2; n++) begin ops[n] = 0; wcnt[n] = 0; waiting[n] = 1'b0; end
        for (int c = 0; c < cycles; c++) begin
            step();
            for (int n = 0; n < 2; n++) begin
                rd_s[n] = 1'b0; wr_s[n] = 1'b0;
                if (waiting[n]) begin
                    wcnt[n]++;
                    if (seen_vld[n] || wcnt[n] > 12) begin waiting[n] = 1'b0; ops[n]--; end
                end
                if (!req_s[n]) begin
                    if ($urandom_range(3) == 0) begin
                        req_s[n] = 1'b1;
                        ops[n] = int'($urandom_range(4, 1));
                    end
                end else if (gnt_of(n) && !waiting[n]) begin
                    if (ops[n] > 0) begin
                        if ($urandom_range(1) == 1) begin
                            wr_s[n]   = 1'($urandom_range(1));
                            rd_s[n]   = !wr_s[n];
                            addr_s[n] = 16'hD000 + 16'(4 * $urandom_range(15));
                            wdat_s[n] = $urandom;
                            waiting[n] = 1'b1;
                            wcnt[n] = 0;
                        end
                    end else if ($urandom_range(2) == 0) begin
                        req_s[n] = 1'b0;
                    end
                end
                if (rogue && $urandom_range(31) == 0) begin
                    rd_s[n]   = 1'($urandom_range(1));
                    wr_s[n]   = !rd_s[n];
                    addr_s[n] = 16'hD000 + 16'(4 * $urandom_range(15));
                    wdat_s[n] = $urandom;
                end
            end
        end
        step();
        clear_inputs();
        idle = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!m0.gnt && !m1.gnt) begin idle = 1'b1; break; end
        end
        check_output("wind_down_idle", 32'(idle), 32'h1);
    endtask

    // ---------------- main sequence ----------------
    int          who;
    logic [31:0] rdata;
    logic [7:0]  bval;

    initial begin
        clear_inputs();
        ram_valid_s = 1'b0;
        ram_rdata_s = '0;
        rst = 1'b0;

        // Reset values while rst is held low.
        @(negedge clk);
        check_output("reset_gnt0", 32'(m0.gnt), 32'h0);
        check_output("reset_gnt1", 32'(m1.gnt), 32'h0);
        check_output("reset_proto_err", 32'(proto_err), 32'h0);
        check_output("reset_ram_rd", 32'(ram_rd), 32'h0);
        do_reset();
        step();

        // m0 alone: four reads against a 1-cycle RAM.
        $display("[TB] m0 read burst");
        ram_lat = 1;
        req_s[0] = 1'b1;
        @(negedge clk);
        check_output("burst_gnt_before", 32'(m0.gnt), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            rd_s[0] = 1'b1;
            addr_s[0] = 16'h0020 + 16'(4 * i);
            @(negedge clk);
            check_output("burst_gnt", 32'(m0.gnt), 32'h1);
            check_output("burst_ram_rd", 32'(ram_rd), 32'h1);
            check_output("burst_ram_addr", 32'(ram_address), 32'h0020 + 32'(4 * i));
            step();
            rd_s[0] = 1'b0;
            @(negedge clk);
            bval = 8'h08 + 8'(i);
            check_output("burst_valid0", 32'(m0.data_valid), 32'h1);
            check_output("burst_data0", m0.data_rd, {4{bval}});
            check_output("burst_valid1", 32'(m1.data_valid), 32'h0);
        end
        release_req(0);

        // Simultaneous requests from reset: m0 first, then alternation.
        $display("[TB] priority alternation");
        do_reset();
        req_s[0] = 1'b1; req_s[1] = 1'b1;
        @(negedge clk);
        check_output("fresh_no_gnt", 32'({m1.gnt, m0.gnt}), 32'h0);
        step();
        @(negedge clk);
        check_output("first_edge_no_gnt", 32'({m1.gnt, m0.gnt}), 32'h0);
        step();
        @(negedge clk);
        check_output("second_edge_gnt0", 32'({m1.gnt, m0.gnt}), 32'h1);
        apply_stimulus(0, 1'b0, 16'h0100, 32'h0, rdata);
        release_req(0);
        check_output("dead_cycle_gnt1", 32'(m1.gnt), 32'h0);
        wait_grant(who);
        check_output("second_owner", 32'(who), 32'h1);
        release_req(1);
        step();
        req_s[0] = 1'b1; req_s[1] = 1'b1;
        wait_grant(who);
        check_output("repeat_tie_owner", 32'(who), 32'h1);
        release_req(1);
        wait_grant(who);
        check_output("repeat_tie_next", 32'(who), 32'h0);
        release_req(0);

        // m1 write then read-back while m0 waits.
        $display("[TB] m1 write/read with m0 waiting");
        step();
        req_s[1] = 1'b1;
        wait_grant(who);
        check_output("m1_owner", 32'(who), 32'h1);
        step();
        req_s[0] = 1'b1;
        apply_stimulus(1, 1'b1, 16'hD030, 32'h0000_1234, rdata);
        check_output("m0_blocked", 32'(m0.gnt), 32'h0);
        apply_stimulus(1, 1'b0, 16'hD030, 32'h0, rdata);
        check_output("readback_D030", rdata, 32'h0000_1234);
        release_req(1);
        wait_grant(who);
        check_output("m0_after_m1", 32'(who), 32'h0);
        release_req(0);

        // m0 drops req on the cycle of its read.
        $display("[TB] release with access in flight");
        step();
        req_s[0] = 1'b1;
        wait_grant(who);
        step();
        rd_s[0] = 1'b1; addr_s[0] = 16'h0040; req_s[0] = 1'b0;
        @(negedge clk);
        check_output("drop_ram_rd", 32'(ram_rd), 32'h1);
        step();
        rd_s[0] = 1'b0;
        @(negedge clk);
        check_output("drop_gnt_held", 32'(m0.gnt), 32'h1);
        check_output("drop_valid0", 32'(m0.data_valid), 32'h1);
        check_output("drop_data0", m0.data_rd, 32'h1010_1010);
        release_req(0);

        // Well-behaved random traffic with variable RAM latency.
        $display("[TB] random traffic");
        ram_lat = 3;
        random_phase(400, 1'b0);
        check_output("clean_proto_err", 32'(proto_err), 32'h0);

        // m1 pulses rd while m0 owns the bus.
        $display("[TB] protocol violation");
        ram_lat = 1;
        step();
        req_s[0] = 1'b1;
        wait_grant(who);
        step();
        rd_s[1] = 1'b1; addr_s[1] = 16'h0080;
        @(negedge clk);
        check_output("viol_no_ram_rd", 32'(ram_rd), 32'h0);
        step();
        rd_s[1] = 1'b0;
        @(negedge clk);
        check_output("viol_proto_err", 32'(proto_err), 32'h1);
        repeat (5) step();
        @(negedge clk);
        check_output("viol_sticky", 32'(proto_err), 32'h1);
        release_req(0);

        // Reset during an outstanding m0 read.
        $display("[TB] reset mid-access");
        ram_lat = 3;
        step();
        req_s[0] = 1'b1;
        wait_grant(who);
        step();
        rd_s[0] = 1'b1; addr_s[0] = 16'h0060;
        step();
        rd_s[0] = 1'b0;
        rst = 1'b0;
        #1;
        check_output("async_gnt0", 32'(m0.gnt), 32'h0);
        check_output("async_ram_rd", 32'(ram_rd), 32'h0);
        check_output("async_proto_err", 32'(proto_err), 32'h0);
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        req_s[1] = 1'b1;
        wait_grant(who);
        check_output("post_reset_owner", 32'(who), 32'h1);
        apply_stimulus(1, 1'b0, 16'h0060, 32'h0, rdata);
        check_output("post_reset_read", rdata, 32'h1818_1818);
        release_req(1);

        // Random traffic with stray pulses.
        $display("[TB] random traffic with violations");
        random_phase(400, 1'b1);

        $display("test done: total=%0d bad=%0d", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
